// File: rtl/riio_pwr_seq_ctrl.sv
// riio_pwr_seq_ctrl: ordered power-up / reverse power-down of N_CH IO-ring
// supply and body-bias domains, with settle delay, power-good timeout and fault.
// Ports:
//   clk, rst (sync, active-high)
//   req_on_i          level request (1 = on, 0 = off)
//   pg_i[N_CH]        per-domain power-good (already synchronised)
//   dly_i[CNT_W]      settle cycles per step (0 treated as 1)
//   en_o[N_CH]        per-domain enable (registered)
//   ready_o, busy_o   sequencer status
//   fault_o, fault_ch_o  sticky fault and faulting domain index
module riio_pwr_seq_ctrl #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int TO_CYC = 4096,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_on_i,
    input  logic [N_CH-1:0]   pg_i,
    input  logic [CNT_W-1:0]  dly_i,
    output logic [N_CH-1:0]   en_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              fault_o,
    output logic [CH_W-1:0]   fault_ch_o
);

    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UP, S_WAIT_PG, S_ON, S_DOWN, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  d_q, d_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic              fault_q, fault_d;
    logic [CH_W-1:0]   fch_q, fch_d;
    logic              ready_q, busy_q;

    logic [CNT_W-1:0]  d_eff;
    logic [CH_W-1:0]   low_idx;
    logic [CH_W-1:0]   idx_inc, idx_dec;

    assign d_eff   = (dly_i == '0) ? CNT_W'(1) : dly_i;
    assign idx_inc = idx_q + CH_W'(1);
    assign idx_dec = idx_q - CH_W'(1);

    // Lowest-numbered domain whose power-good is low.
    always_comb begin
        low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (!pg_i[i]) low_idx = CH_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            d_q     <= CNT_W'(1);
            tcnt_q  <= '0;
            en_q    <= '0;
            fault_q <= 1'b0;
            fch_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            tcnt_q  <= tcnt_d;
            en_q    <= en_d;
            fault_q <= fault_d;
            fch_q   <= fch_d;
            ready_q <= (state_d == S_ON);
            busy_q  <= (state_d == S_UP) || (state_d == S_WAIT_PG) ||
                       (state_d == S_DOWN);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        tcnt_d  = tcnt_q;
        en_d    = en_q;
        fault_d = fault_q;
        fch_d   = fch_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_on_i) begin
                    d_d     = d_eff;
                    idx_d   = '0;
                    cnt_d   = CNT_W'(1);
                    en_d[0] = 1'b1;
                    state_d = S_UP;
                end
            end
            S_UP: begin
                if (!req_on_i) begin
                    // Abort: unwind from the domain just enabled.
                    en_d[idx_q] = 1'b0;
                    cnt_d       = CNT_W'(1);
                    state_d     = S_DOWN;
                end else if (cnt_q >= d_q) begin
                    tcnt_d  = '0;
                    state_d = S_WAIT_PG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_PG: begin
                if (!req_on_i) begin
                    en_d[idx_q] = 1'b0;
                    cnt_d       = CNT_W'(1);
                    state_d     = S_DOWN;
                end else if (pg_i[idx_q]) begin
                    if (idx_q == LAST) begin
                        state_d = S_ON;
                    end else begin
                        idx_d         = idx_inc;
                        en_d[idx_inc] = 1'b1;
                        cnt_d         = CNT_W'(1);
                        state_d       = S_UP;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    en_d    = '0;
                    fault_d = 1'b1;
                    fch_d   = idx_q;
                    state_d = S_FAULT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_ON: begin
                // A lost power-good outranks a simultaneous off request.
                if (!(&pg_i)) begin
                    en_d    = '0;
                    fault_d = 1'b1;
                    fch_d   = low_idx;
                    state_d = S_FAULT;
                end else if (!req_on_i) begin
                    d_d        = d_eff;
                    idx_d      = LAST;
                    en_d[LAST] = 1'b0;
                    cnt_d      = CNT_W'(1);
                    state_d    = S_DOWN;
                end
            end
            S_DOWN: begin
                if (cnt_q >= d_q) begin
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d         = idx_dec;
                        en_d[idx_dec] = 1'b0;
                        cnt_d         = CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FAULT: begin
                if (!req_on_i) begin
                    fault_d = 1'b0;
                    fch_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                en_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign en_o       = en_q;
    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign fault_o    = fault_q;
    assign fault_ch_o = fch_q;

endmodule

// File: tb/tb_riio_pwr_seq_ctrl.sv
// Scoreboard bench for riio_pwr_seq_ctrl (N_CH=4, TO_CYC=8).
// Stimulus queues cycle-stamped expected outputs; a negedge monitor checks them.
module tb_riio_pwr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_on_i;
    logic [3:0] pg_i;
    logic [15:0] dly_i;
    logic [3:0] en_o;
    logic       ready_o;
    logic       busy_o;
    logic       fault_o;
    logic [1:0] fault_ch_o;

    riio_pwr_seq_ctrl #(
        .N_CH(4), .CNT_W(16), .TO_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .req_on_i(req_on_i), .pg_i(pg_i),
        .dly_i(dly_i), .en_o(en_o), .ready_o(ready_o), .busy_o(busy_o),
        .fault_o(fault_o), .fault_ch_o(fault_ch_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] en;
        logic       rdy;
        logic       bsy;
        logic       flt;
        logic [1:0] fch;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int n_chk = 0;
    int n_fail = 0;

    task automatic push(input int at, input logic [3:0] en, input logic r,
                        input logic b, input logic f, input logic [1:0] fc,
                        input string nm);
        exp_t e;
        e.at = at; e.en = en; e.rdy = r; e.bsy = b; e.flt = f;
        e.fch = fc; e.nm = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            m_e = sb.pop_front();
            n_chk++;
            if (m_e.at != cyc) begin
                n_fail++;
                $display("FAIL %s: due cycle %0d checked at %0d",
                         m_e.nm, m_e.at, cyc);
            end else if ({en_o, ready_o, busy_o, fault_o, fault_ch_o} !==
                         {m_e.en, m_e.rdy, m_e.bsy, m_e.flt, m_e.fch}) begin
                n_fail++;
                $display("FAIL %s @%0d: got en=%b rdy=%b busy=%b flt=%b ch=%0d, expected en=%b rdy=%b busy=%b flt=%b ch=%0d",
                         m_e.nm, cyc, en_o, ready_o, busy_o, fault_o,
                         fault_ch_o, m_e.en, m_e.rdy, m_e.bsy, m_e.flt,
                         m_e.fch);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    int t;

    initial begin
        rst = 1'b1;
        req_on_i = 1'b0;
        pg_i = 4'hF;
        dly_i = 16'd3;
        tick(); tick(); tick();
        rst = 1'b0;
        push(cyc, 4'b0000, 0, 0, 0, 2'd0, "reset");
        tick(); tick();

        // Power-up, D=3, pg high
        t = cyc;
        req_on_i = 1'b1;
        push(t + 1,  4'b0001, 0, 1, 0, 2'd0, "up_en0");
        push(t + 4,  4'b0001, 0, 1, 0, 2'd0, "up_wait0");
        push(t + 5,  4'b0011, 0, 1, 0, 2'd0, "up_en1");
        push(t + 9,  4'b0111, 0, 1, 0, 2'd0, "up_en2");
        push(t + 13, 4'b1111, 0, 1, 0, 2'd0, "up_en3");
        push(t + 16, 4'b1111, 0, 1, 0, 2'd0, "up_busy_end");
        push(t + 17, 4'b1111, 1, 0, 0, 2'd0, "up_ready");
        wait_until(t + 20);

        // Power-down from ON
        t = cyc;
        req_on_i = 1'b0;
        push(t + 1,  4'b0111, 0, 1, 0, 2'd0, "dn_3off");
        push(t + 3,  4'b0111, 0, 1, 0, 2'd0, "dn_hold");
        push(t + 4,  4'b0011, 0, 1, 0, 2'd0, "dn_2off");
        push(t + 7,  4'b0001, 0, 1, 0, 2'd0, "dn_1off");
        push(t + 10, 4'b0000, 0, 1, 0, 2'd0, "dn_0off");
        push(t + 12, 4'b0000, 0, 1, 0, 2'd0, "dn_busy_end");
        push(t + 13, 4'b0000, 0, 0, 0, 2'd0, "dn_idle");
        wait_until(t + 15);

        // Power-good timeout on ch2
        pg_i = 4'b1011;
        t = cyc;
        req_on_i = 1'b1;
        push(t + 1,  4'b0001, 0, 1, 0, 2'd0, "to_en0");
        push(t + 9,  4'b0111, 0, 1, 0, 2'd0, "to_en2");
        push(t + 19, 4'b0111, 0, 1, 0, 2'd0, "to_last_wait");
        push(t + 20, 4'b0000, 0, 0, 1, 2'd2, "to_fault");
        push(t + 21, 4'b0000, 0, 0, 1, 2'd2, "to_sticky");
        wait_until(t + 22);
        t = cyc;
        req_on_i = 1'b0;
        push(t + 1, 4'b0000, 0, 0, 0, 2'd0, "to_clear");
        wait_until(t + 3);
        pg_i = 4'hF;

        // ON fault beats simultaneous off request
        t = cyc;
        req_on_i = 1'b1;
        push(t + 17, 4'b1111, 1, 0, 0, 2'd0, "on_ready");
        wait_until(t + 19);
        t = cyc;
        pg_i = 4'b1001;
        req_on_i = 1'b0;
        push(t + 1, 4'b0000, 0, 0, 1, 2'd1, "on_fault_ch1");
        push(t + 2, 4'b0000, 0, 0, 0, 2'd0, "on_fault_clear");
        wait_until(t + 4);
        pg_i = 4'hF;

        // Abort while ch2 in UP, D=2
        dly_i = 16'd2;
        t = cyc;
        req_on_i = 1'b1;
        push(t + 1,  4'b0001, 0, 1, 0, 2'd0, "ab_en0");
        push(t + 4,  4'b0011, 0, 1, 0, 2'd0, "ab_en1");
        push(t + 7,  4'b0111, 0, 1, 0, 2'd0, "ab_en2");
        wait_until(t + 7);
        req_on_i = 1'b0;
        push(t + 8,  4'b0011, 0, 1, 0, 2'd0, "ab_2off");
        push(t + 10, 4'b0001, 0, 1, 0, 2'd0, "ab_1off");
        push(t + 12, 4'b0000, 0, 1, 0, 2'd0, "ab_0off");
        push(t + 14, 4'b0000, 0, 0, 0, 2'd0, "ab_idle");
        wait_until(t + 16);

        // dly=0 acts as 1; reset while ch1 in WAIT_PG
        dly_i = 16'd0;
        pg_i = 4'b1101;
        t = cyc;
        req_on_i = 1'b1;
        push(t + 1, 4'b0001, 0, 1, 0, 2'd0, "d0_en0");
        push(t + 3, 4'b0011, 0, 1, 0, 2'd0, "d0_en1");
        push(t + 5, 4'b0011, 0, 1, 0, 2'd0, "d0_wait1");
        wait_until(t + 5);
        rst = 1'b1;
        push(t + 6, 4'b0000, 0, 0, 0, 2'd0, "rst_mid");
        tick();
        req_on_i = 1'b0;
        tick();
        rst = 1'b0;
        pg_i = 4'hF;
        tick();

        // Full power-up with D=1
        t = cyc;
        req_on_i = 1'b1;
        push(t + 8, 4'b1111, 0, 1, 0, 2'd0, "d1_wait3");
        push(t + 9, 4'b1111, 1, 0, 0, 2'd0, "d1_ready");
        wait_until(t + 10);
        req_on_i = 1'b0;

        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
